// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write sequencer.
package rf_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int unsigned DWIDTH_DEF = 32;
   localparam int unsigned WIDTH_DEF  = 5;
   localparam int unsigned RWIDTH_DEF = 16;
   localparam int unsigned NREQ_DEF   = 3;
   localparam int unsigned GID_WIDTH  = $clog2(NREQ_DEF);

endpackage

// File: rtl/regfile_write_sequencer_rr_arbiter.sv
// Combinational round-robin picker: grants the first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_gnt
);

   int unsigned idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr) + i) % N;
         if (!any_gnt && req[IW'(idx)]) begin
            gnt[IW'(idx)] = 1'b1;
            gnt_idx       = IW'(idx);
            any_gnt       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the register file write port: round-robin writeback arbitration plus a
// hardware clear sequence that writes zero to registers 1..RWIDTH-1.
module regfile_write_sequencer
   import rf_ctrl_pkg::*;
#(
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned RWIDTH = RWIDTH_DEF,
   parameter int unsigned NREQ   = NREQ_DEF
) (
   input  logic                          Clk,
   input  logic                          N_Rst,
   input  logic [NREQ-1:0]               Req_Valid,
   output logic [NREQ-1:0]               Req_Ready,
   input  logic [NREQ-1:0][WIDTH-1:0]    Req_Addr,
   input  logic [NREQ-1:0][DWIDTH-1:0]   Req_Data,
   input  logic                          Clr_Start,
   output logic                          Clr_Busy,
   output logic                          WE3,
   output logic [WIDTH-1:0]              WA3,
   output logic [DWIDTH-1:0]             WD3,
   output logic [$clog2(NREQ)-1:0]       Grant_Id
);

   localparam int unsigned     GW       = $clog2(NREQ);
   localparam logic [WIDTH-1:0] CLR_LAST = WIDTH'(RWIDTH - 1);
   localparam logic [WIDTH:0]   ADDR_LIM = (WIDTH + 1)'(RWIDTH);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   clr_cnt;
   logic [GW-1:0]      rr_ptr;
   logic               run_en;
   logic [NREQ-1:0]    gnt;
   logic [GW-1:0]      gnt_idx;
   logic               any_gnt;
   logic               hs;
   logic [WIDTH-1:0]   acc_addr;
   logic [DWIDTH-1:0]  acc_data;
   logic               addr_ok;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req     (Req_Valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   always_ff @(posedge Clk or negedge N_Rst) begin
      if (!N_Rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Clr_Start) state_nxt = CLEAR;
         CLEAR:   if (clr_cnt == CLR_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // run_en keeps Req_Ready low through reset and the first cycle after release.
   always_comb begin
      Req_Ready = '0;
      Clr_Busy  = 1'b0;
      case (state)
         IDLE:    if (run_en && !Clr_Start) Req_Ready = gnt;
         CLEAR:   Clr_Busy = 1'b1;
         default: ;
      endcase
   end

   assign hs       = any_gnt && (Req_Ready != '0);
   assign acc_addr = Req_Addr[gnt_idx];
   assign acc_data = Req_Data[gnt_idx];
   assign addr_ok  = (acc_addr != '0) && ({1'b0, acc_addr} < ADDR_LIM);

   always_ff @(posedge Clk or negedge N_Rst) begin
      if (!N_Rst) begin
         run_en   <= 1'b0;
         clr_cnt  <= '0;
         rr_ptr   <= '0;
         WE3      <= 1'b0;
         WA3      <= '0;
         WD3      <= '0;
         Grant_Id <= '0;
      end else begin
         run_en <= 1'b1;
         WE3    <= 1'b0;
         if (state == CLEAR) begin
            WE3 <= 1'b1;
            WA3 <= clr_cnt;
            WD3 <= '0;
            if (clr_cnt != CLR_LAST) clr_cnt <= clr_cnt + 1'b1;
         end else if (Clr_Start) begin
            clr_cnt <= WIDTH'(1);
         end else if (hs) begin
            WE3      <= addr_ok;
            WA3      <= acc_addr;
            WD3      <= acc_data;
            Grant_Id <= gnt_idx;
            rr_ptr   <= (gnt_idx == GW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed and random stimulus against a queue-based reference of the write sequencer.
module tb_regfile_write_sequencer;
   import rf_ctrl_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned RW = 16;
   localparam int unsigned NR = 3;
   localparam int unsigned GW = $clog2(NR);

   logic                      Clk = 1'b0;
   logic                      N_Rst;
   logic [NR-1:0]             Req_Valid;
   logic [NR-1:0]             Req_Ready;
   logic [NR-1:0][AW-1:0]     Req_Addr;
   logic [NR-1:0][DW-1:0]     Req_Data;
   logic                      Clr_Start;
   logic                      Clr_Busy;
   logic                      WE3;
   logic [AW-1:0]             WA3;
   logic [DW-1:0]             WD3;
   logic [GW-1:0]             Grant_Id;

   int total = 0;
   int bad   = 0;

   // reference state
   int            m_ptr;
   bit            m_en;
   int            clr_q[$];
   logic          m_we;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;
   logic [GW-1:0] m_gid;
   int            hcount[NR];

   regfile_write_sequencer #(
      .DWIDTH (DW),
      .WIDTH  (AW),
      .RWIDTH (RW),
      .NREQ   (NR)
   ) dut (
      .Clk       (Clk),
      .N_Rst     (N_Rst),
      .Req_Valid (Req_Valid),
      .Req_Ready (Req_Ready),
      .Req_Addr  (Req_Addr),
      .Req_Data  (Req_Data),
      .Clr_Start (Clr_Start),
      .Clr_Busy  (Clr_Busy),
      .WE3       (WE3),
      .WA3       (WA3),
      .WD3       (WD3),
      .Grant_Id  (Grant_Id)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_en  = 1'b0;
      clr_q.delete();
      m_we  = 1'b0;
      m_wa  = '0;
      m_wd  = '0;
      m_gid = '0;
   endtask

   function automatic logic [NR-1:0] model_ready();
      logic [NR-1:0] r;
      r = '0;
      if (!m_en || clr_q.size() != 0 || Clr_Start) return r;
      for (int k = 0; k < NR; k++) begin
         int c;
         c = (m_ptr + k) % NR;
         if (Req_Valid[GW'(c)]) begin
            r[GW'(c)] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic check_outputs();
      chk("WE3",      64'(WE3),      64'(m_we));
      chk("WA3",      64'(WA3),      64'(m_wa));
      chk("WD3",      64'(WD3),      64'(m_wd));
      chk("Grant_Id", 64'(Grant_Id), 64'(m_gid));
      chk("Clr_Busy", 64'(Clr_Busy), 64'(clr_q.size() != 0));
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic tick();
      logic [NR-1:0] er;
      logic [NR-1:0] hs;
      #2;
      er = model_ready();
      chk("Req_Ready", 64'(Req_Ready), 64'(er));
      @(posedge Clk);
      hs = er & Req_Valid;
      if (!N_Rst) begin
         model_reset();
      end else begin
         if (clr_q.size() != 0) begin
            m_wa = AW'(clr_q.pop_front());
            m_we = 1'b1;
            m_wd = '0;
         end else if (Clr_Start) begin
            for (int a = 1; a < RW; a++) clr_q.push_back(a);
            m_we = 1'b0;
         end else if (hs != '0) begin
            int g;
            g = 0;
            for (int k = 0; k < NR; k++) if (hs[GW'(k)]) g = k;
            m_we  = (int'(Req_Addr[GW'(g)]) != 0) && (int'(Req_Addr[GW'(g)]) < RW);
            m_wa  = Req_Addr[GW'(g)];
            m_wd  = Req_Data[GW'(g)];
            m_gid = GW'(g);
            m_ptr = (g + 1) % NR;
            hcount[g]++;
         end else begin
            m_we = 1'b0;
         end
         m_en = 1'b1;
      end
      #1;
      check_outputs();
   endtask

   initial begin
      int seq[6];
      int cnt[NR];
      int busy;
      int ptr_before;

      N_Rst     = 1'b0;
      Req_Valid = '0;
      Req_Addr  = '0;
      Req_Data  = '0;
      Clr_Start = 1'b0;
      for (int k = 0; k < NR; k++) hcount[k] = 0;
      model_reset();
      #1;

      // reset held with random requests
      for (int i = 0; i < 3; i++) begin
         Req_Valid = NR'($urandom);
         Req_Addr  = (NR * AW)'($urandom);
         tick();
      end
      chk("rst_Req_Ready", 64'(Req_Ready), 64'(0));
      chk("rst_WE3", 64'(WE3), 64'(0));

      // release, then a single write from requester 1
      N_Rst     = 1'b1;
      Req_Valid = 3'b010;
      Req_Addr  = '0;
      Req_Addr[1] = 5'd5;
      Req_Data[1] = 32'hDEADBEEF;
      tick();
      tick();
      chk("first_WE3", 64'(WE3), 64'(1));
      chk("first_WA3", 64'(WA3), 64'(5));
      chk("first_WD3", 64'(WD3), 64'(32'hDEADBEEF));
      chk("first_Grant_Id", 64'(Grant_Id), 64'(1));

      // requester 2 once so the pointer returns to 0
      Req_Valid   = 3'b100;
      Req_Addr[2] = 5'd3;
      Req_Data[2] = $urandom;
      tick();

      // fairness: everyone valid for 6 cycles
      for (int k = 0; k < NR; k++) cnt[k] = 0;
      Req_Valid = '1;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < NR; k++) begin
            Req_Addr[k] = AW'(k + 1);
            Req_Data[k] = $urandom;
         end
         tick();
         seq[i] = int'(Grant_Id);
         if (WE3) cnt[Grant_Id]++;
      end
      for (int i = 0; i < 6; i++) chk("rr_seq", 64'(seq[i]), 64'(i % 3));
      for (int k = 0; k < NR; k++) chk("rr_count", 64'(cnt[k]), 64'(2));

      // dropped writes to x0 and out of range, then a legal top register
      Req_Valid   = 3'b001;
      Req_Addr[0] = 5'd0;
      tick();
      chk("drop0_WE3", 64'(WE3), 64'(0));
      Req_Addr[0] = 5'd16;
      tick();
      chk("drop16_WE3", 64'(WE3), 64'(0));
      chk("drop16_WA3", 64'(WA3), 64'(16));
      Req_Addr[0] = 5'd15;
      tick();
      chk("top_WE3", 64'(WE3), 64'(1));
      chk("top_WA3", 64'(WA3), 64'(15));

      // clear sequence with all requesters valid
      Req_Valid  = '1;
      ptr_before = m_ptr;
      Clr_Start  = 1'b1;
      tick();
      Clr_Start = 1'b0;
      busy = Clr_Busy ? 1 : 0;
      for (int i = 0; i < 20 && Clr_Busy; i++) begin
         tick();
         if (Clr_Busy) busy++;
      end
      chk("clr_busy_cycles", 64'(busy), 64'(RW - 1));
      chk("clr_last_WA3", 64'(WA3), 64'(RW - 1));
      #2;
      chk("clr_resume_ready", 64'(Req_Ready), 64'(NR'(1) << ptr_before));
      tick();
      Req_Valid = '0;
      tick();

      // Clr_Start collides with a request from requester 2
      Req_Valid   = 3'b100;
      Req_Addr[2] = 5'd9;
      Req_Data[2] = 32'h0BADF00D;
      Clr_Start   = 1'b1;
      tick();
      chk("coll_busy", 64'(Clr_Busy), 64'(1));
      chk("coll_WE3", 64'(WE3), 64'(0));
      Clr_Start = 1'b0;
      for (int i = 0; i < 20 && clr_q.size() != 0; i++) tick();
      tick();
      chk("coll_after_WE3", 64'(WE3), 64'(1));
      chk("coll_after_WA3", 64'(WA3), 64'(9));
      chk("coll_after_Grant_Id", 64'(Grant_Id), 64'(2));
      Req_Valid = '0;
      tick();

      // asynchronous reset in the middle of a clear
      Clr_Start = 1'b1;
      tick();
      Clr_Start = 1'b0;
      for (int i = 0; i < 20 && WA3 !== 5'd7; i++) tick();
      chk("midclr_reach7", 64'(WA3), 64'(7));
      N_Rst = 1'b0;
      #1;
      model_reset();
      chk("midclr_WE3", 64'(WE3), 64'(0));
      chk("midclr_WA3", 64'(WA3), 64'(0));
      chk("midclr_WD3", 64'(WD3), 64'(0));
      chk("midclr_Grant_Id", 64'(Grant_Id), 64'(0));
      chk("midclr_busy", 64'(Clr_Busy), 64'(0));
      tick();
      tick();
      N_Rst = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("post_rst_busy", 64'(Clr_Busy), 64'(0));
      chk("post_rst_WE3", 64'(WE3), 64'(0));

      // random traffic with occasional clears
      for (int i = 0; i < 400; i++) begin
         Req_Valid = NR'($urandom);
         for (int k = 0; k < NR; k++) begin
            Req_Addr[k] = AW'($urandom);
            Req_Data[k] = $urandom;
         end
         Clr_Start = ($urandom_range(0, 29) == 0);
         tick();
      end
      Clr_Start = 1'b0;
      Req_Valid = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
